// File: rtl/match_ctl.sv
// rtl/match_ctl.sv - two-player match sequencer: countdown, goal detection, scoring, winner
module match_ctl #(
    parameter int WIN_SCORE    = 5,
    parameter int COUNT_STEPS  = 3,
    parameter int COUNT_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int Y_TOP        = 0,
    parameter int Y_BOTTOM     = 767
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        v_tick_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [11:0] ypos_ball_i,
    output logic [2:0]  phase_o,
    output logic        freeze_o,
    output logic        serve_req_o,
    output logic        serve_to_o,
    output logic [1:0]  countdown_o,
    output logic [3:0]  score1_o,
    output logic [3:0]  score2_o,
    output logic [1:0]  winner_o
);

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_COUNT = 3'd1,
        PH_PLAY  = 3'd2,
        PH_POINT = 3'd3,
        PH_OVER  = 3'd4
    } phase_e;

    localparam logic [1:0]  STEPS   = 2'(COUNT_STEPS);
    localparam logic [3:0]  WIN     = 4'(WIN_SCORE);
    localparam logic [11:0] Y_T     = 12'(Y_TOP);
    localparam logic [11:0] Y_B     = 12'(Y_BOTTOM);
    localparam logic [15:0] CF_LAST = 16'(COUNT_FRAMES - 1);
    localparam logic [15:0] PF_LAST = 16'(POINT_FRAMES - 1);

    phase_e      phase_q, phase_d;
    logic        freeze_q, freeze_d;
    logic        serve_req_q, serve_req_d;
    logic        serve_to_q, serve_to_d;
    logic [1:0]  countdown_q, countdown_d;
    logic [3:0]  score1_q, score1_d;
    logic [3:0]  score2_q, score2_d;
    logic [1:0]  winner_q, winner_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        v_tick_q, start_q;

    logic        frame_tick, start_edge;
    logic [3:0]  score1_inc, score2_inc;

    assign frame_tick = v_tick_i & ~v_tick_q;
    assign start_edge = start_i & ~start_q;
    assign score1_inc = score1_q + 4'd1;
    assign score2_inc = score2_q + 4'd1;

    // State and output registers; reset drops the game back to a frozen idle board at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q     <= PH_IDLE;
            freeze_q    <= 1'b1;
            serve_req_q <= 1'b0;
            serve_to_q  <= 1'b0;
            countdown_q <= 2'd0;
            score1_q    <= 4'd0;
            score2_q    <= 4'd0;
            winner_q    <= 2'd0;
            frame_cnt_q <= 16'd0;
            v_tick_q    <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            freeze_q    <= freeze_d;
            serve_req_q <= serve_req_d;
            serve_to_q  <= serve_to_d;
            countdown_q <= countdown_d;
            score1_q    <= score1_d;
            score2_q    <= score2_d;
            winner_q    <= winner_d;
            frame_cnt_q <= frame_cnt_d;
            v_tick_q    <= v_tick_i;
            start_q     <= start_i;
        end
    end

    // Next phase and next outputs; abort is applied last so it beats start and tick
    always_comb begin
        phase_d     = phase_q;
        serve_req_d = 1'b0;
        serve_to_d  = serve_to_q;
        countdown_d = countdown_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        winner_d    = winner_q;
        frame_cnt_d = frame_cnt_q;

        case (phase_q)
            PH_IDLE, PH_OVER: begin
                // A coincident frame tick is deliberately not counted here
                if (start_edge) begin
                    score1_d    = 4'd0;
                    score2_d    = 4'd0;
                    winner_d    = 2'd0;
                    countdown_d = STEPS;
                    frame_cnt_d = 16'd0;
                    phase_d     = PH_COUNT;
                end
            end
            PH_COUNT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == CF_LAST) begin
                        frame_cnt_d = 16'd0;
                        if (countdown_q == 2'd1) begin
                            countdown_d = 2'd0;
                            serve_req_d = 1'b1;
                            phase_d     = PH_PLAY;
                        end else begin
                            countdown_d = countdown_q - 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            PH_PLAY: begin
                if (frame_tick) begin
                    if (ypos_ball_i <= Y_T) begin
                        serve_to_d = 1'b0;
                        if (score1_q < WIN) score1_d = score1_inc;
                        if (score1_inc >= WIN) begin
                            winner_d = 2'd1;
                            phase_d  = PH_OVER;
                        end else begin
                            frame_cnt_d = 16'd0;
                            phase_d     = PH_POINT;
                        end
                    end else if (ypos_ball_i >= Y_B) begin
                        serve_to_d = 1'b1;
                        if (score2_q < WIN) score2_d = score2_inc;
                        if (score2_inc >= WIN) begin
                            winner_d = 2'd2;
                            phase_d  = PH_OVER;
                        end else begin
                            frame_cnt_d = 16'd0;
                            phase_d     = PH_POINT;
                        end
                    end
                end
            end
            PH_POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == PF_LAST) begin
                        frame_cnt_d = 16'd0;
                        countdown_d = STEPS;
                        phase_d     = PH_COUNT;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase

        if (abort_i) begin
            phase_d     = PH_IDLE;
            serve_req_d = 1'b0;
            countdown_d = 2'd0;
            score1_d    = 4'd0;
            score2_d    = 4'd0;
            winner_d    = 2'd0;
            frame_cnt_d = 16'd0;
        end
    end

    assign freeze_d = (phase_d != PH_PLAY);

    assign phase_o     = phase_q;
    assign freeze_o    = freeze_q;
    assign serve_req_o = serve_req_q;
    assign serve_to_o  = serve_to_q;
    assign countdown_o = countdown_q;
    assign score1_o    = score1_q;
    assign score2_o    = score2_q;
    assign winner_o    = winner_q;

endmodule

// File: tb/tb_match_ctl.sv
// tb/tb_match_ctl.sv - directed bench for match_ctl
module tb_match_ctl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v_tick;
    logic        start;
    logic        abort;
    logic [11:0] ypos;
    logic [2:0]  phase;
    logic        freeze;
    logic        serve_req;
    logic        serve_to;
    logic [1:0]  countdown;
    logic [3:0]  score1;
    logic [3:0]  score2;
    logic [1:0]  winner;

    int checks = 0;
    int errors = 0;

    match_ctl #(
        .WIN_SCORE   (2),
        .COUNT_STEPS (3),
        .COUNT_FRAMES(2),
        .POINT_FRAMES(3),
        .Y_TOP       (0),
        .Y_BOTTOM    (767)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .v_tick_i   (v_tick),
        .start_i    (start),
        .abort_i    (abort),
        .ypos_ball_i(ypos),
        .phase_o    (phase),
        .freeze_o   (freeze),
        .serve_req_o(serve_req),
        .serve_to_o (serve_to),
        .countdown_o(countdown),
        .score1_o   (score1),
        .score2_o   (score2),
        .winner_o   (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            v_tick = 1'b1;
            step();
            v_tick = 1'b0;
            step();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        v_tick = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        ypos   = 12'd400;
        step();
        step();
        check("rst_phase", phase, 0);
        check("rst_freeze", freeze, 1);
        check("rst_score1", score1, 0);
        check("rst_winner", winner, 0);
        rst_n = 1'b1;
        step();

        // Frame ticks without start leave the board idle
        frames(10);
        check("idle_phase", phase, 0);
        check("idle_freeze", freeze, 1);

        // Countdown 3,2,1 at two frames per digit
        start = 1'b1;
        step();
        check("cd_phase", phase, 1);
        check("cd_start", countdown, 3);
        start = 1'b0;
        step();
        frames(1);
        check("cd_tick1", countdown, 3);
        frames(1);
        check("cd_tick2", countdown, 2);
        frames(2);
        check("cd_tick4", countdown, 1);
        frames(1);
        v_tick = 1'b1;
        step();
        check("play_phase", phase, 2);
        check("play_serve", serve_req, 1);
        check("play_cd", countdown, 0);
        check("play_freeze", freeze, 0);
        v_tick = 1'b0;
        step();
        check("serve_pulse", serve_req, 0);

        // Goal for player 1 only counts on a frame tick
        ypos = 12'd0;
        repeat (4) step();
        check("notick_s1", score1, 0);
        check("notick_ph", phase, 2);
        frames(1);
        check("goal1_s1", score1, 1);
        check("goal1_to", serve_to, 0);
        check("goal1_ph", phase, 3);
        ypos = 12'd400;
        frames(2);
        check("point_t2", phase, 3);
        frames(1);
        check("point_t3", phase, 1);
        check("point_cd", countdown, 3);

        // Goal for player 2
        frames(6);
        check("play2_ph", phase, 2);
        ypos = 12'd767;
        frames(1);
        check("goal2_s2", score2, 1);
        check("goal2_to", serve_to, 1);
        check("goal2_ph", phase, 3);

        // Second player-2 goal wins
        frames(3);
        frames(6);
        check("play3_ph", phase, 2);
        frames(1);
        check("win_ph", phase, 4);
        check("win_who", winner, 2);
        check("win_s2", score2, 2);
        check("win_freeze", freeze, 1);
        frames(3);
        check("over_s2", score2, 2);
        check("over_s1", score1, 1);

        // Restart from OVER
        pulse_start();
        check("rs_ph", phase, 1);
        check("rs_s1", score1, 0);
        check("rs_s2", score2, 0);
        check("rs_win", winner, 0);

        // Reach PLAY with score1 = 1
        ypos = 12'd400;
        frames(6);
        ypos = 12'd0;
        frames(1);
        check("ab_s1", score1, 1);
        ypos = 12'd400;
        frames(3);
        frames(6);
        check("ab_play", phase, 2);

        // Start edge is ignored during PLAY
        pulse_start();
        check("ign_start", phase, 2);

        // Abort beats simultaneous start edge and frame tick
        abort  = 1'b1;
        start  = 1'b1;
        v_tick = 1'b1;
        ypos   = 12'd0;
        step();
        check("ab_ph", phase, 0);
        check("ab_s1z", score1, 0);
        check("ab_serve", serve_req, 0);
        check("ab_freeze", freeze, 1);
        abort  = 1'b0;
        start  = 1'b0;
        v_tick = 1'b0;
        ypos   = 12'd400;
        step();

        // Tick coincident with start in IDLE is not counted
        start  = 1'b1;
        v_tick = 1'b1;
        step();
        check("co_ph", phase, 1);
        start  = 1'b0;
        v_tick = 1'b0;
        step();
        frames(1);
        check("co_t1", countdown, 3);
        frames(1);
        check("co_t2", countdown, 2);

        // Asynchronous reset mid-countdown
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ph", phase, 0);
        check("async_cd", countdown, 0);
        check("async_fr", freeze, 1);
        step();
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
